// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: op codes, access-size decode,
// FSM state encodings and the read-latency range check.
package mem_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic [1:0] size;
    logic       is_signed;
  } op_dec_t;

  // Unassigned codes decode as NONE (no load, no store, byte size).
  function automatic op_dec_t op_decode(input logic [3:0] op);
    op_dec_t d;
    d = '0;
    case (op)
      OP_LB:   begin d.is_load = 1'b1; d.size = SZ_B; d.is_signed = 1'b1; end
      OP_LBU:  begin d.is_load = 1'b1; d.size = SZ_B; end
      OP_LH:   begin d.is_load = 1'b1; d.size = SZ_H; d.is_signed = 1'b1; end
      OP_LHU:  begin d.is_load = 1'b1; d.size = SZ_H; end
      OP_LW:   begin d.is_load = 1'b1; d.size = SZ_W; end
      OP_SB:   begin d.is_store = 1'b1; d.size = SZ_B; end
      OP_SH:   begin d.is_store = 1'b1; d.size = SZ_H; end
      OP_SW:   begin d.is_store = 1'b1; d.size = SZ_W; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic bit rd_lat_ok(input int unsigned lat);
    return lat <= 3;
  endfunction

endpackage

// File: rtl/ls_align.sv
// Combinational load/store alignment: store strobes and lane replication,
// load byte/halfword extraction with sign/zero extension, misalignment check.
module ls_align
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wen,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misaligned
);

  op_dec_t     dec;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    dec        = op_decode(op);
    misaligned = ((dec.size == SZ_H) && addr_lo[0]) ||
                 ((dec.size == SZ_W) && (addr_lo != 2'd0));
    misaligned = misaligned && (dec.is_load || dec.is_store);

    wen   = '0;
    wdata = sdata;
    case (dec.size)
      SZ_B: begin
        wdata = {4{sdata[7:0]}};
        wen   = 4'b0001 << addr_lo;
      end
      SZ_H: begin
        wdata = {2{sdata[15:0]}};
        wen   = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = sdata;
        wen   = 4'b1111;
      end
    endcase
    if (!dec.is_store || misaligned) wen = '0;

    byte_sel = 8'(rdata >> {addr_lo, 3'b000});
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (dec.size)
      SZ_B:    ldata = dec.is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      SZ_H:    ldata = dec.is_signed ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access stage between EXE and WB: one operation in flight, registered
// RAM address/strobes, RD_LAT-cycle load wait and a held valid/ready result.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_sdata,
  input  logic              in_rf_wen,
  input  logic [4:0]        in_rf_wdest,
  input  logic [ADDR_W-1:0] in_pc,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_wen,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_rf_wen,
  output logic [4:0]        out_rf_wdest,
  output logic [31:0]       out_result,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_excp,
  output logic [ADDR_W-1:0] out_badvaddr
);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("mem_stage_lsu: RD_LAT must be in 0..3");
  end

  localparam logic [1:0] CNT_LAST = 2'((RD_LAT == 0) ? 0 : RD_LAT - 1);

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic [3:0]        op_q;
  logic              rf_wen_q;
  logic [4:0]        wdest_q;
  logic [ADDR_W-1:0] pc_q;
  logic              excp_q;

  op_dec_t     dec_q;
  logic        load_ok;
  logic        done_now;
  logic [31:0] fin_result;

  logic [3:0]  al_op;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_wen;
  logic [31:0] al_wdata;
  logic [31:0] al_ldata;
  logic        al_misaligned;

  // One aligner serves both ends: incoming op while IDLE, latched op afterwards.
  assign al_op      = (state == S_IDLE) ? in_op : op_q;
  assign al_addr_lo = (state == S_IDLE) ? in_addr[1:0] : dm_addr[1:0];

  ls_align u_align (
    .op         (al_op),
    .addr_lo    (al_addr_lo),
    .sdata      (in_sdata),
    .rdata      (dm_rdata),
    .wen        (al_wen),
    .wdata      (al_wdata),
    .ldata      (al_ldata),
    .misaligned (al_misaligned)
  );

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_comb begin
    dec_q      = op_decode(op_q);
    load_ok    = dec_q.is_load && !excp_q;
    fin_result = load_ok ? al_ldata : 32'(dm_addr);
    done_now   = ((state == S_ACCESS) && (!load_ok || (RD_LAT == 0))) ||
                 ((state == S_WAIT) && (cnt == CNT_LAST));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      op_q         <= '0;
      rf_wen_q     <= 1'b0;
      wdest_q      <= '0;
      pc_q         <= '0;
      excp_q       <= 1'b0;
      dm_addr      <= '0;
      dm_wen       <= '0;
      dm_wdata     <= '0;
      out_rf_wen   <= 1'b0;
      out_rf_wdest <= '0;
      out_result   <= '0;
      out_pc       <= '0;
      out_excp     <= 1'b0;
      out_badvaddr <= '0;
    end else begin
      dm_wen <= '0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state    <= S_ACCESS;
            op_q     <= in_op;
            rf_wen_q <= in_rf_wen;
            wdest_q  <= in_rf_wdest;
            pc_q     <= in_pc;
            excp_q   <= al_misaligned;
            dm_addr  <= in_addr;
            dm_wen   <= al_wen;
            dm_wdata <= al_wdata;
          end
        end
        S_ACCESS: begin
          cnt <= '0;
          if (load_ok && (RD_LAT != 0)) state <= S_WAIT;
        end
        S_WAIT:  cnt <= cnt + 2'd1;
        default: if (out_ready) state <= S_IDLE;
      endcase

      if (done_now) begin
        state        <= S_DONE;
        out_rf_wen   <= rf_wen_q && !excp_q;
        out_rf_wdest <= wdest_q;
        out_result   <= fin_result;
        out_pc       <= pc_q;
        out_excp     <= excp_q;
        out_badvaddr <= excp_q ? dm_addr : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with RD_LAT=2 and a small byte-writable RAM
// model whose read data trails dm_addr by two clocks.
module tb_mem_stage_lsu;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_sdata;
  logic        in_rf_wen;
  logic [4:0]  in_rf_wdest;
  logic [31:0] in_pc;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wen;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        out_valid;
  logic        out_ready;
  logic        out_rf_wen;
  logic [4:0]  out_rf_wdest;
  logic [31:0] out_result;
  logic [31:0] out_pc;
  logic        out_excp;
  logic [31:0] out_badvaddr;

  int n_pass  = 0;
  int n_total = 0;
  int wen_pulses = 0;
  int lat;
  int p0;

  logic [31:0] mem [0:63];
  logic [31:0] rd_q1, rd_q2;

  mem_stage_lsu #(.RD_LAT(LAT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_sdata(in_sdata), .in_rf_wen(in_rf_wen), .in_rf_wdest(in_rf_wdest), .in_pc(in_pc),
    .dm_addr(dm_addr), .dm_wen(dm_wen), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rf_wen(out_rf_wen),
    .out_rf_wdest(out_rf_wdest), .out_result(out_result), .out_pc(out_pc),
    .out_excp(out_excp), .out_badvaddr(out_badvaddr)
  );

  always #5 clk = ~clk;

  // RAM model: byte writes on strobes, read data follows the address by LAT clocks.
  always @(posedge clk) begin
    rd_q1 <= dm_addr;
    rd_q2 <= rd_q1;
    if (rst) mem[8] <= 32'h80FF7F01;
    for (int b = 0; b < 4; b++)
      if (dm_wen[b]) mem[dm_addr[7:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
    if (dm_wen != 4'd0) wen_pulses <= wen_pulses + 1;
  end
  assign dm_rdata = mem[rd_q2[7:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Presents one op while IDLE; returns in the ACCESS cycle after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] wd, input logic [31:0] pc);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_sdata = sd;
    in_rf_wen = 1'b1; in_rf_wdest = wd; in_pc = pc;
    step();
    in_valid = 1'b0; in_op = 4'd0; in_addr = '0; in_sdata = '0;
  endtask

  // Latency counted in cycles after the accept cycle; capped at 20.
  task automatic await_valid(output int l);
    l = 1;
    while (!out_valid && l < 20) begin
      step();
      l++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] exp);
    issue(op, addr, 32'd0, 5'd7, 32'h200);
    await_valid(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_data"}, out_result, exp);
    chk({tag, "_rfwen"}, 32'(out_rf_wen), 32'd1);
    handshake();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_addr = '0; in_sdata = '0;
    in_rf_wen = 1'b0; in_rf_wdest = '0; in_pc = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dm_wen", 32'(dm_wen), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    rst = 1'b0;
    step();

    // SW aligned word
    p0 = wen_pulses;
    issue(4'd8, 32'h10, 32'hDEADBEEF, 5'd3, 32'h100);
    chk("sw_wen", 32'(dm_wen), 32'hF);
    chk("sw_wdata", dm_wdata, 32'hDEADBEEF);
    chk("sw_addr", dm_addr, 32'h10);
    chk("sw_in_ready", 32'(in_ready), 32'd0);
    await_valid(lat);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_wen_off", 32'(dm_wen), 32'd0);
    chk("sw_result", out_result, 32'h10);
    chk("sw_pc", out_pc, 32'h100);
    chk("sw_excp", 32'(out_excp), 32'd0);
    chk("sw_pulses", 32'(wen_pulses - p0), 32'd1);
    handshake();
    chk("sw_back_idle", 32'(in_ready), 32'd1);
    chk("sw_valid_drop", 32'(out_valid), 32'd0);

    // SB to the top byte lane
    issue(4'd6, 32'h13, 32'h000000A5, 5'd0, 32'h104);
    chk("sb_wen", 32'(dm_wen), 32'h8);
    chk("sb_wdata", dm_wdata, 32'hA5A5A5A5);
    await_valid(lat);
    chk("sb_lat", 32'(lat), 32'd2);
    chk("sb_result", out_result, 32'h13);
    handshake();

    // Loads with RD_LAT=2
    load_case("lw_merged", 4'd5, 32'h10, 32'hA5ADBEEF);
    load_case("lb_1", 4'd1, 32'h21, 32'h0000007F);
    load_case("lb_3", 4'd1, 32'h23, 32'hFFFFFF80);
    load_case("lhu_2", 4'd4, 32'h22, 32'h000080FF);
    load_case("lh_2", 4'd3, 32'h22, 32'hFFFF80FF);
    load_case("lbu_3", 4'd2, 32'h23, 32'h00000080);
    chk("ld_wdest", 32'(out_rf_wdest), 32'd7);

    // Misaligned LW
    p0 = wen_pulses;
    issue(4'd5, 32'h06, 32'd0, 5'd9, 32'h300);
    chk("mis_wen", 32'(dm_wen), 32'd0);
    await_valid(lat);
    chk("mis_lat", 32'(lat), 32'd2);
    chk("mis_excp", 32'(out_excp), 32'd1);
    chk("mis_badvaddr", out_badvaddr, 32'h06);
    chk("mis_rfwen", 32'(out_rf_wen), 32'd0);
    chk("mis_pulses", 32'(wen_pulses - p0), 32'd0);
    handshake();

    // Unassigned op code passes the address through
    issue(4'd12, 32'hCAFE0001, 32'd0, 5'd2, 32'h304);
    await_valid(lat);
    chk("none_lat", 32'(lat), 32'd2);
    chk("none_result", out_result, 32'hCAFE0001);
    chk("none_excp", 32'(out_excp), 32'd0);
    handshake();

    // SH held in DONE for five cycles
    p0 = wen_pulses;
    issue(4'd7, 32'h12, 32'h00001234, 5'd4, 32'h400);
    chk("sh_wen", 32'(dm_wen), 32'hC);
    chk("sh_wdata", dm_wdata, 32'h12341234);
    await_valid(lat);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_result", out_result, 32'h12);
      chk("stall_pc", out_pc, 32'h400);
      step();
    end
    chk("stall_pulses", 32'(wen_pulses - p0), 32'd1);
    handshake();

    // Reset during WAIT of an LW, then a clean LW
    issue(4'd5, 32'h20, 32'd0, 5'd5, 32'h500);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_in_ready", 32'(in_ready), 32'd1);
    chk("rstw_out_valid", 32'(out_valid), 32'd0);
    chk("rstw_dm_wen", 32'(dm_wen), 32'd0);
    load_case("lw_after_rst", 4'd5, 32'h20, 32'h80FF7F01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
